// File: rtl/stopwatch_disp.sv
// Stopwatch: BCD SS.CC count (00.00..59.99) plus a 4-digit common-anode seven-segment scanner.
// Latency: bcd updates one edge after a sampled tick; an/seg are registered, one edge behind the display value.
// No backpressure: mode pauses the count, clr zeroes it; define STOPWATCH_LAP_EN to enable lap freeze.
module stopwatch_disp #(
  parameter int TICK_DIV = 500_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mode,
  input  logic        clr,
  input  logic        lap,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [15:0]   bcd_inc;
  logic [15:0]   disp;

  logic [SW-1:0] scnt;
  logic          scan_wrap;
  logic [1:0]    dig;
  logic [1:0]    dig_nxt;
  logic [3:0]    nib;
  logic [3:0]    an_nxt;
  logic [7:0]    seg_nxt;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} with dp dark.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // A tick only fires while running, so pausing on the terminal count suppresses it.
  assign tick = mode && (pcnt == PMAX);

  // Ripple-carry BCD increment; sec_tens rolls 5->0, giving 59.99 -> 00.00.
  always_comb begin
    bcd_inc = bcd;
    if (bcd[3:0] != 4'd9) begin
      bcd_inc[3:0] = bcd[3:0] + 4'd1;
    end else begin
      bcd_inc[3:0] = 4'd0;
      if (bcd[7:4] != 4'd9) begin
        bcd_inc[7:4] = bcd[7:4] + 4'd1;
      end else begin
        bcd_inc[7:4] = 4'd0;
        if (bcd[11:8] != 4'd9) begin
          bcd_inc[11:8] = bcd[11:8] + 4'd1;
        end else begin
          bcd_inc[11:8] = 4'd0;
          if (bcd[15:12] != 4'd5) begin
            bcd_inc[15:12] = bcd[15:12] + 4'd1;
          end else begin
            bcd_inc[15:12] = 4'd0;
          end
        end
      end
    end
  end

  // Prescaler, live count and sticky wrap flag; clr beats a coincident tick.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcnt <= '0;
      bcd  <= '0;
      ovf  <= 1'b0;
    end else if (clr) begin
      pcnt <= '0;
      bcd  <= '0;
      ovf  <= 1'b0;
    end else if (mode) begin
      if (tick) begin
        pcnt <= '0;
        bcd  <= bcd_inc;
        if (bcd == 16'h5999) begin
          ovf <= 1'b1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        frz;
  logic [15:0] lap_bcd;

  // Lap pulse toggles freeze; the live count is captured on entry only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frz     <= 1'b0;
      lap_bcd <= '0;
    end else if (clr) begin
      frz <= 1'b0;
    end else if (lap) begin
      if (!frz) begin
        lap_bcd <= bcd;
      end
      frz <= ~frz;
    end
  end

  assign disp = frz ? lap_bcd : bcd;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign disp       = bcd;
`endif

  // Next digit slot and its segment pattern; computed from the index being entered.
  always_comb begin
    scan_wrap = (scnt == SMAX);
    dig_nxt   = scan_wrap ? dig + 2'd1 : dig;
    case (dig_nxt)
      2'd0:    nib = disp[3:0];
      2'd1:    nib = disp[7:4];
      2'd2:    nib = disp[11:8];
      default: nib = disp[15:12];
    endcase
    an_nxt  = ~(4'b0001 << dig_nxt);
    seg_nxt = seg_code(nib);
    if (dig_nxt == 2'd2) begin
      seg_nxt[7] = 1'b0;
    end
  end

  // Free-running scan; an and seg share one register stage so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scnt <= '0;
      dig  <= 2'd0;
      an   <= 4'b1110;
      seg  <= 8'hC0;
    end else begin
      scnt <= scan_wrap ? '0 : scnt + 1'b1;
      dig  <= dig_nxt;
      an   <= an_nxt;
      seg  <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_disp.sv
// Bench for stopwatch_disp with a centisecond-integer reference model and directed stimulus.
// Model outputs are compared on every falling edge; literal checks pin key points.
// Lap expectations follow STOPWATCH_LAP_EN as defined for the build.
module tb_stopwatch_disp;

  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mode;
  logic        clr;
  logic        lap;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  an;
  logic [7:0]  seg;

  int n_checks = 0;
  int n_err    = 0;

  stopwatch_disp #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .clr(clr), .lap(lap),
    .bcd(bcd), .ovf(ovf), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_pc, m_cnt, m_scnt, m_idx, m_lap, m_disp;
  logic       m_ovf, m_frz, m_valid = 1'b0;
  logic [3:0] m_an;
  logic [7:0] m_seg;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: seg_of = 8'hC0;  1: seg_of = 8'hF9;  2: seg_of = 8'hA4;  3: seg_of = 8'hB0;
      4: seg_of = 8'h99;  5: seg_of = 8'h92;  6: seg_of = 8'h82;  7: seg_of = 8'hF8;
      8: seg_of = 8'h80;  9: seg_of = 8'h90;  default: seg_of = 8'hFF;
    endcase
  endfunction

  function automatic int digit_of(input int cs, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    digit_of = (cs / p) % 10;
  endfunction

  function automatic logic [15:0] bcd_of(input int cs);
    bcd_of = {4'(digit_of(cs, 3)), 4'(digit_of(cs, 2)), 4'(digit_of(cs, 1)), 4'(digit_of(cs, 0))};
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_pc = 0; m_cnt = 0; m_ovf = 1'b0; m_scnt = 0; m_idx = 0;
      m_an = 4'b1110; m_seg = 8'hC0; m_frz = 1'b0; m_lap = 0;
    end else begin
      if (m_scnt == SD - 1) begin
        m_scnt = 0;
        m_idx  = (m_idx + 1) % 4;
      end else begin
        m_scnt = m_scnt + 1;
      end
      m_disp = m_frz ? m_lap : m_cnt;
      m_an   = 4'hF ^ (4'h1 << m_idx);
      m_seg  = seg_of(digit_of(m_disp, m_idx)) & ((m_idx == 2) ? 8'h7F : 8'hFF);
      if (clr) begin
        m_pc = 0; m_cnt = 0; m_ovf = 1'b0; m_frz = 1'b0;
      end else begin
`ifdef STOPWATCH_LAP_EN
        if (lap) begin
          if (!m_frz) m_lap = m_cnt;
          m_frz = !m_frz;
        end
`endif
        if (mode) begin
          if (m_pc == TD - 1) begin
            m_pc = 0;
            if (m_cnt == 5999) begin
              m_cnt = 0;
              m_ovf = 1'b1;
            end else begin
              m_cnt = m_cnt + 1;
            end
          end else begin
            m_pc = m_pc + 1;
          end
        end
      end
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_bcd", 32'(bcd), 32'(bcd_of(m_cnt)));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
      chk("cyc_an",  32'(an),  32'(m_an));
      chk("cyc_seg", 32'(seg), 32'(m_seg));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic pulse_clr;
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  function automatic logic [7:0] lit_seg(input logic [3:0] a, input logic frozen);
    lit_seg = 8'h00;
    case (a)
      4'b1110: lit_seg = frozen ? 8'h99 : 8'hA4;
      4'b1101: lit_seg = frozen ? 8'hB0 : 8'h99;
      4'b1011: lit_seg = 8'h24;
      4'b0111: lit_seg = 8'hF9;
      default: lit_seg = 8'h00;
    endcase
  endfunction

  logic [3:0] an_s  [8];
  logic [7:0] seg_s [8];
  logic       frozen_build;

  task automatic sample_scan(input string tag, input logic frozen);
    for (int i = 0; i < 8; i++) begin
      neg;
      an_s[i]  = an;
      seg_s[i] = seg;
    end
    for (int i = 0; i < 8; i++) chk({tag, "_seg"}, 32'(seg_s[i]), 32'(lit_seg(an_s[i], frozen)));
    for (int i = 0; i < 6; i++) chk({tag, "_an_rot"}, 32'(an_s[i + 2]), 32'({an_s[i][2:0], an_s[i][3]}));
  endtask

  initial begin
`ifdef STOPWATCH_LAP_EN
    frozen_build = 1'b1;
`else
    frozen_build = 1'b0;
`endif
    rstn = 1'b0; mode = 1'b0; clr = 1'b0; lap = 1'b0;

    // Reset
    step(3);
    neg;
    chk("rst_bcd", 32'(bcd), 32'h0000);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_an",  32'(an),  32'hE);
    chk("rst_seg", 32'(seg), 32'hC0);
    rstn = 1'b1;
    step(1);
    neg;
    chk("post_rst_an",  32'(an),  32'hE);
    chk("post_rst_seg", 32'(seg), 32'hC0);

    // Run 40 cycles -> 10 ticks
    mode = 1'b1; step(40); mode = 1'b0;
    neg;
    chk("run_bcd", 32'(bcd), 32'h0010);

    // Pause holds prescaler
    pulse_clr;
    mode = 1'b1; step(6); mode = 1'b0;
    neg; chk("pause_a", 32'(bcd), 32'h0001);
    step(20);
    neg; chk("pause_b", 32'(bcd), 32'h0001);
    mode = 1'b1; step(2); mode = 1'b0;
    neg; chk("pause_c", 32'(bcd), 32'h0002);

    // Wrap 59.99 -> 00.00 sets ovf
    pulse_clr;
    mode = 1'b1; step(5999 * TD);
    neg;
    chk("pre_wrap_bcd", 32'(bcd), 32'h5999);
    chk("pre_wrap_ovf", 32'(ovf), 32'h0);
    step(TD); mode = 1'b0;
    neg;
    chk("wrap_bcd", 32'(bcd), 32'h0000);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    step(3);
    neg; chk("ovf_sticky", 32'(ovf), 32'h1);
    pulse_clr;
    neg; chk("clr_ovf", 32'(ovf), 32'h0);

    // Clear beats a coincident tick and zeroes the prescaler
    mode = 1'b1; step(2 * TD - 1);
    neg; chk("cw_pre", 32'(bcd), 32'h0001);
    clr = 1'b1; step(1); clr = 1'b0;
    neg; chk("cw_bcd", 32'(bcd), 32'h0000);
    step(TD - 1);
    neg; chk("cw_pc0", 32'(bcd), 32'h0000);
    step(1); mode = 1'b0;
    neg; chk("cw_tick", 32'(bcd), 32'h0001);

    // Lap at 12.34, then 8 more ticks
    pulse_clr;
    mode = 1'b1; step(1234 * TD); mode = 1'b0;
    neg; chk("lap_pre", 32'(bcd), 32'h1234);
    lap = 1'b1; step(1); lap = 1'b0;
    mode = 1'b1; step(8 * TD); mode = 1'b0;
    neg; chk("lap_live", 32'(bcd), 32'h1242);
    step(1);
    sample_scan("lap1", frozen_build);

    // Second lap releases the freeze
    lap = 1'b1; step(1); lap = 1'b0;
    step(1);
    sample_scan("lap2", 1'b0);
    chk("lap2_bcd", 32'(bcd), 32'h1242);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_disp.md
# stopwatch_disp

Stopwatch core and 4-digit seven-segment driver sitting directly downstream of the debounced mode-toggle stage. It consumes the level `mode` signal: `mode`=1 runs the count, `mode`=0 pauses it. The count is a BCD seconds.centiseconds value from 00.00 to 59.99. It is time-multiplexed onto a common-anode 4-digit display.

## Interface
- `TICK_DIV`, default 500_000: clock cycles per centisecond tick (10 ms at 50 MHz).
- `SCAN_DIV`, default 50_000: clock cycles per display digit slot (1 ms at 50 MHz).
- `clk` input 1: system clock, 50 MHz.
- `rstn` input 1: reset, synchronous, active-low.
- `mode` input 1: run/pause level from the mode-toggle stage. 1 = run.
- `clr` input 1: synchronous clear, active-high, level.
- `lap` input 1: lap/freeze pulse, one cycle wide. Used only with `LAP_EN`.
- `bcd` output 16: live count {sec_tens, sec_ones, cs_tens, cs_ones}, 4 bits each.
- `ovf` output 1: sticky wrap flag.
- `an` output 4: digit enables, active-low. `an[0]` is the rightmost digit (cs_ones).
- `seg` output 8: segments, active-low. Bit layout {dp,g,f,e,d,c,b,a}.

## Operation
- Prescaler `pcnt` has range 0..TICK_DIV-1.
  - It increments only while `mode`=1.
  - A tick occurs when `pcnt`=TICK_DIV-1 and `mode`=1; `pcnt` then returns to 0.
  - While `mode`=0, `pcnt` holds its value, so a partial interval resumes on the next run.
- On each tick the BCD chain increments.
  - cs_ones 9→0 carries into cs_tens.
  - cs_tens 9→0 carries into sec_ones.
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 with all lower digits at 9 is the wrap: 59.99→00.00, and `ovf` is set.
- Every digit stays in 0–9; sec_tens stays in 0–5. There are no illegal BCD states.
- `clr`=1 sets `pcnt`, `bcd` and `ovf` to 0. It has priority over a simultaneous tick and does not depend on `mode`. The scan counter is unaffected.
- `ovf` remains set until `clr` or reset.
- Scan counter `scnt` has range 0..SCAN_DIV-1.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - Scanning is free-running and independent of `mode`.
- Digit index k drives `an` = ~(1<<k) and shows the selected nibble of the display value.
- Segment codes are active-low hex for 0–9: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- dp (bit 7) is driven low, i.e. lit, only on digit 2 (sec_ones). This forms SS.CC.

## Timing
- All registers update on `posedge clk`.
- Reset values: `pcnt`=0, `scnt`=0, digit index 0, `bcd`=16'h0000, `ovf`=0, `an`=4'b1110, `seg`=8'hC0.
- Tick to `bcd` latency: `bcd` shows the new value on the cycle after the clock edge where the tick condition is sampled true.
- `an` and `seg` are registered and change together on the edge where the digit index advances, so there is no cross-digit glitch.
- A `mode` change takes effect on the next edge. `mode` going 1→0 on the tick cycle suppresses that tick.
- Reset mid-count returns every output to its reset value on the next edge, regardless of `clr`, `mode` or `lap`.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - A `lap` pulse toggles the freeze state.
  - On entering freeze, `bcd` is latched into a lap register, and the display shows the lap register while the live count continues.
  - The next `lap` pulse releases the freeze, and the display shows live `bcd` again.
  - `clr` also releases the freeze.
  - The freeze state resets to 0.
  - `bcd` output is always the live count.
- Undefined: the `lap` port is present but ignored, there is no lap register, and the display always shows live `bcd`.

## Test plan
Bench parameters: TICK_DIV=4, SCAN_DIV=2.
- Reset: hold `rstn`=0 for 3 cycles, then release. Expect `bcd`=0000, `ovf`=0, `an`=1110, `seg`=C0, held until the first scan wrap.
- Run: `mode`=1 for 40 cycles. Expect `bcd`=0010, i.e. 10 ticks with cs_ones carrying into cs_tens.
- Pause: `mode`=1 for 6 cycles, `mode`=0 for 20 cycles, `mode`=1 for 2 cycles. Expect `bcd`=0002 and 0001 during the pause, because the pause holds `pcnt`.
- Wrap: preload by running 5999 ticks to 59.99, then one more tick. Expect `bcd`=0000 and `ovf`=1. Then `clr` for 1 cycle. Expect `ovf`=0.
- Clear wins: assert `clr` on the exact tick cycle. Expect `bcd`=0000 and `pcnt`=0 on the next cycle.
- Scan and lap (`STOPWATCH_LAP_EN` defined):
  - At `bcd`=1234, pulse `lap`, then run 8 more ticks.
  - During the run, expect `an` to cycle 1110→1101→1011→0111 every 2 cycles.
  - Expect `seg` to show 4, 3, 2-with-dp (=24), 1 (=F9), and `bcd`=1242.
  - A second `lap` pulse shows live 1242.
